// File: rtl/halfduplex_bus_master.sv
// halfduplex_bus_master: sequences one half-duplex single-wire transaction per
// request. It shifts out a command byte MSB first, releases the line for a
// turnaround gap, then shifts in a response byte through a 2-flop synchronizer.
// Optional feature macro: HDBUS_PARITY_EN. When defined, frames carry a 9th
// odd-parity bit and par_err reports a bad received parity.
module halfduplex_bus_master #(
  parameter int BIT_DIV   = 4,
  parameter int TURN_BITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       par_err,
  output logic       bus_dout,
  output logic       bus_en,
  input  logic       bus_in
);

`ifdef HDBUS_PARITY_EN
  localparam int SR_W = 9;
`else
  localparam int SR_W = 8;
`endif
  localparam int TMR_W = $clog2(BIT_DIV);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(BIT_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_MID    = TMR_W'(BIT_DIV / 2);
  localparam logic [3:0]       FRAME_LAST = 4'(SR_W - 1);
  localparam logic [3:0]       TURN_LAST  = 4'(TURN_BITS - 1);

  typedef enum logic [1:0] {IDLE, SEND, TURN, RECV} state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [SR_W-1:0]   shift_q, shift_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              bus_en_q, bus_en_d;
  logic              bus_dout_q, bus_dout_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              wrap;
  logic [SR_W-1:0]   load_w;
`ifdef HDBUS_PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  // Next-state logic: bit timing, frame sequencing and line control.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    bus_en_d   = bus_en_q;
    bus_dout_d = bus_dout_q;
    sync1_d    = bus_in;
    sync2_d    = sync1_q;
`ifdef HDBUS_PARITY_EN
    par_err_d  = par_err_q;
    // Parity bit makes the total count of ones over the 9-bit frame odd.
    load_w     = {cmd, ~^cmd};
`else
    load_w     = cmd;
`endif
    wrap = (timer_q == TMR_LAST);
    // Timer idles at zero so a new transaction starts on a clean bit boundary.
    if (state_q == IDLE || wrap) timer_d = '0;
    else                         timer_d = timer_q + TMR_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = load_w;
          bit_cnt_d  = '0;
          state_d    = SEND;
          bus_en_d   = 1'b1;
          bus_dout_d = load_w[SR_W-1];
`ifdef HDBUS_PARITY_EN
          par_err_d  = 1'b0;
`endif
        end
      end
      SEND: begin
        if (wrap) begin
          if (bit_cnt_q == FRAME_LAST) begin
            state_d    = TURN;
            bit_cnt_d  = '0;
            bus_en_d   = 1'b0;
            bus_dout_d = 1'b0;
          end else begin
            bit_cnt_d  = bit_cnt_q + 4'd1;
            shift_d    = shift_q << 1;
            bus_dout_d = shift_q[SR_W-2];
          end
        end
      end
      TURN: begin
        if (wrap) begin
          if (bit_cnt_q == TURN_LAST) begin
            state_d   = RECV;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      RECV: begin
        // Mid-period sample leaves margin for the synchronizer latency.
        if (timer_q == TMR_MID) shift_d = {shift_q[SR_W-2:0], sync2_q};
        if (wrap) begin
          if (bit_cnt_q == FRAME_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            rdata_d = shift_q[SR_W-1 -: 8];
`ifdef HDBUS_PARITY_EN
            par_err_d = ~^shift_q;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; async reset releases the line immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      bus_en_q   <= 1'b0;
      bus_dout_q <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
`ifdef HDBUS_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      bus_en_q   <= bus_en_d;
      bus_dout_q <= bus_dout_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
`ifdef HDBUS_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign bus_en   = bus_en_q;
  assign bus_dout = bus_dout_q;
`ifdef HDBUS_PARITY_EN
  assign par_err  = par_err_q;
`else
  assign par_err  = 1'b0;
`endif

endmodule

// File: tb/tb_halfduplex_bus_master.sv
// Testbench for halfduplex_bus_master: randomized transactions checked
// cycle by cycle against a timing/frame model derived from the bus protocol.
module tb_halfduplex_bus_master;
  localparam int BD = 4;
  localparam int TB = 2;
`ifdef HDBUS_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif
  localparam int RB  = (FRAME + TB) * BD;      // first receive cycle offset
  localparam int LAT = (2 * FRAME + TB) * BD;  // offset of the done cycle

  logic       clk, rst_n, start, bus_in;
  logic [7:0] cmd;
  logic       busy, done, par_err, bus_dout, bus_en;
  logic [7:0] rdata;

  int         n_chk, n_pass;
  logic [7:0] exp_rdata;
  logic       exp_par;

  halfduplex_bus_master #(.BIT_DIV(BD), .TURN_BITS(TB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd),
    .busy(busy), .done(done), .rdata(rdata), .par_err(par_err),
    .bus_dout(bus_dout), .bus_en(bus_en), .bus_in(bus_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  // Bit j of the transmitted frame, MSB first; bit 8 is the odd-parity bit.
  function automatic logic sent_bit(input logic [7:0] c, input int j);
    logic [7:0] v;
    v = c;
    if (j < 8) return v[7 - j];
    return ($countones(v) % 2 == 0);
  endfunction

  function automatic logic recv_bit(input logic [7:0] r, input logic p, input int j);
    logic [7:0] v;
    v = r;
    if (j < 8) return v[7 - j];
    return p;
  endfunction

  // Runs one transaction whose start/cmd the caller has already driven.
  // chain: keep start high in the done cycle with cmd=nc.
  // abort_at: cycle offset at which reset is pulled low (-1 = never).
  task automatic txn(input logic [7:0] c, input logic [7:0] r, input logic p,
                     input bit chain, input logic [7:0] nc, input int abort_at);
    logic e_en, e_dout;
    @(posedge clk);
`ifdef HDBUS_PARITY_EN
    exp_par = 1'b0;
`endif
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_bus_en", 32'(bus_en), 32'd0);
        check("rst_bus_dout", 32'(bus_dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_par_err", 32'(par_err), 32'd0);
        exp_rdata = 8'h00;
        exp_par   = 1'b0;
        start     = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("rst_hold_done", 32'(done), 32'd0);
          check("rst_hold_en", 32'(bus_en), 32'd0);
        end
        rst_n = 1'b1;
        return;
      end
      e_en   = (k < FRAME * BD);
      e_dout = e_en ? sent_bit(c, k / BD) : 1'b0;
      if (k == LAT) begin
        exp_rdata = r;
`ifdef HDBUS_PARITY_EN
        exp_par = ($countones({r, p}) % 2 == 0);
`endif
      end
      check("bus_en", 32'(bus_en), 32'(e_en));
      check("bus_dout", 32'(bus_dout), 32'(e_dout));
      check("busy", 32'(busy), 32'(k < LAT));
      check("done", 32'(done), 32'(k == LAT));
      check("rdata", 32'(rdata), 32'(exp_rdata));
      check("par_err", 32'(par_err), 32'(exp_par));
      if (k >= RB) begin
        if ((k - RB) % BD == 0) bus_in = recv_bit(r, p, (k - RB) / BD);
      end else begin
        bus_in = 1'($urandom_range(0, 1));
      end
      if (k < LAT) begin
        start = 1'($urandom_range(0, 1));
        cmd   = 8'($urandom);
      end else begin
        start = chain;
        cmd   = chain ? nc : 8'($urandom);
      end
    end
    if (!chain) begin
      @(negedge clk);
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_bus_en", 32'(bus_en), 32'd0);
      check("idle_rdata", 32'(rdata), 32'(exp_rdata));
    end
  endtask

  initial begin
    logic [7:0] c, nxt;
    bit         ch, chained;
    n_chk = 0; n_pass = 0;
    exp_rdata = 8'h00; exp_par = 1'b0;
    rst_n = 1'b1; start = 1'b0; cmd = 8'h00; bus_in = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_par_err", 32'(par_err), 32'd0);
    check("reset_bus_en", 32'(bus_en), 32'd0);
    check("reset_bus_dout", 32'(bus_dout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: A5 out / 3C back, chained straight into 0F.
    start = 1'b1; cmd = 8'hA5;
    txn(8'hA5, 8'h3C, 1'b0, 1'b1, 8'h0F, -1);
    txn(8'h0F, 8'h5A, 1'b1, 1'b0, 8'h00, -1);

    // Randomized transactions, some back-to-back.
    nxt = 8'($urandom);
    chained = 1'b0;
    for (int i = 0; i < 10; i++) begin
      c   = nxt;
      nxt = 8'($urandom);
      ch  = (i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!chained) begin
        start = 1'b1; cmd = c;
      end
      txn(c, 8'($urandom), 1'($urandom_range(0, 1)), ch, nxt, -1);
      chained = ch;
    end

    // Reset in the middle of the receive phase.
    start = 1'b1; cmd = 8'hC3;
    txn(8'hC3, 8'h99, 1'b0, 1'b0, 8'h00, RB + 3 * BD + 1);

    // Recovery; with parity enabled this returns a bad-parity frame.
    start = 1'b1; cmd = 8'h01;
    txn(8'h01, 8'h03, 1'b0, 1'b0, 8'h00, -1);
    start = 1'b1; cmd = 8'h6E;
    txn(8'h6E, 8'hE7, 1'b1, 1'b0, 8'h00, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/halfduplex_bus_master.md
Name: halfduplex_bus_master

Overview:
- Sequencing stage directly upstream of the tristate pad buffer.
- Generates the buffer's data and enable, and reads the pad back.
- Runs one half-duplex transaction per request: shifts out an 8-bit command, releases the line for a turnaround gap, then shifts in an 8-bit response.
- Sits between the local controller (start/cmd/rdata handshake) and the shared single-wire line.

Parameters:
BIT_DIV, 4, clk cycles per bit period; legal values are even and >= 4.
TURN_BITS, 2, bit periods of line release between the send and receive phases; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  transaction request; sampled only in IDLE.
cmd  input  8  command byte; captured when start is accepted.
busy  output  1  high while a transaction is in progress.
done  output  1  one-cycle pulse at transaction end.
rdata  output  8  received byte; updated at done, held until the next done.
par_err  output  1  receive parity error; see Optional Feature.
bus_dout  output  1  to the tristate buffer data input.
bus_en  output  1  to the tristate buffer enable; 1 drives the line.
bus_in  input  1  pad readback; asynchronous to clk.

Behaviour:
- Reset (async, rst_n=0): the following are forced immediately, not at the next edge.
  - State = IDLE.
  - busy=0, done=0, rdata=8'h00, par_err=0, bus_dout=0, bus_en=0.
  - Bit timer, bit counter and synchronizer are cleared.
- Reset mid-transaction aborts it with no done pulse; the line is released at once.
- States: IDLE -> SEND -> TURN -> RECV -> IDLE.
- busy = (state != IDLE).
- IDLE: on a rising edge with start=1:
  - cmd is latched into the shift register.
  - The timer and bit counter are cleared.
  - State moves to SEND.
- start while busy is ignored; it is not queued.
- Bit timer counts 0..BIT_DIV-1. Each wrap ends one bit period.
- SEND:
  - bus_en=1; bus_dout = current shift register MSB.
  - MSB is transmitted first; each bit is held for exactly BIT_DIV cycles.
  - After 8 bit periods, move to TURN.
- TURN:
  - bus_en=0, bus_dout=0.
  - Lasts TURN_BITS bit periods, then move to RECV.
- RECV:
  - bus_en=0, bus_dout=0.
  - bus_in passes through a 2-flop synchronizer.
  - The synchronized value is sampled when timer == BIT_DIV/2 and shifted in MSB first.
  - After 8 bit periods, the following happen on the same edge:
    - rdata is loaded from the shift register.
    - done=1 for one cycle.
    - State returns to IDLE, so busy=0.
- bus_dout outside SEND is always 0.
- bus_en is registered and glitch-free.
- Back-to-back transactions: start=1 in the cycle where done=1 is accepted (state is already IDLE), giving zero idle cycles between transactions.
- Latency: start accepted at edge E0 -> bus_en rises after E0 -> done is high for the cycle following edge E0+(16+TURN_BITS)*BIT_DIV.
  - With defaults this is E0+72.
  - bus_en falls after edge E0+8*BIT_DIV.
- Bench contract: bus_in is driven stable from the start of each RECV bit period to its end. With BIT_DIV >= 4, the sample point lies inside the period even after the synchronizer delay.

Optional Feature:
Macro: HDBUS_PARITY_EN.
- Defined:
  - SEND transmits 9 bits: the 8 cmd bits, then an odd-parity bit (total ones over the 9 bits is odd).
  - RECV receives 9 bits; rdata takes the first 8.
  - par_err is set with done if the total ones over the received 9 bits is even.
  - par_err holds until cleared at the next accepted start.
  - Latency becomes (18+TURN_BITS)*BIT_DIV, which is 80 with defaults.
- Undefined:
  - 8-bit frames only.
  - par_err is tied 0.
  - No parity logic is present.

Test Plan:
1. Reset, then start=1 for one cycle with cmd=8'hA5 (defaults) -> bus_en=1 for exactly 32 cycles; bus_dout shows 1,0,1,0,0,1,0,1, each bit held 4 cycles; bus_en=0 for the 8 TURN cycles.
2. Same transaction with the bench driving bus_in = 8'h3C MSB first in the RECV periods -> done is a single pulse at E0+72; rdata=8'h3C; busy falls with done.
3. start=1 asserted while busy=1 -> ignored: cmd changes have no effect and the next transaction starts only after done.
4. start held high across done with cmd=8'h0F -> second SEND begins with no idle gap; the first rdata is held until the second done.
5. rst_n pulled low during RECV -> bus_en=0, busy=0 and rdata=8'h00 immediately; no done pulse; after release, a new start works normally.
6. With HDBUS_PARITY_EN defined:
   - cmd=8'h01 -> 9th sent bit is 0.
   - Bench returns 8'h03 with parity bit 0 -> done at E0+80 with par_err=1.
   - The next start clears par_err to 0.
